// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle from the timing generator to its consumers
interface vga_timing_gen_if;
   logic       pixTick;
   logic       active;
   logic [9:0] xPos;
   logic [8:0] yPos;
   logic       hsync;
   logic       vsync;
   logic       frameStart;

   // The timing generator drives every signal in the bundle
   modport master (
      output pixTick,
      output active,
      output xPos,
      output yPos,
      output hsync,
      output vsync,
      output frameStart
   );

   // Pixel colour generator and sync pin drivers only observe
   modport slave (
      input pixTick,
      input active,
      input xPos,
      input yPos,
      input hsync,
      input vsync,
      input frameStart
   );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing with internal pixel-clock enable
module vga_timing_gen #(
   parameter int CLK_DIV  = 4,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SYNC_POL = 0
) (
   input  logic              clk,
   input  logic              reset,
   vga_timing_gen_if.master  vo
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   // Sized decode constants; sync windows are inclusive so they never exceed the total
   localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
   localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT     = HW'(H_ACTIVE);
   localparam logic [VW-1:0] V_ACT     = VW'(V_ACTIVE);
   localparam logic [HW-1:0] HS_FIRST  = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_LAST   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] VS_FIRST  = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_LAST   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic          SYNC_ON   = (SYNC_POL != 0);
   localparam logic          SYNC_OFF  = ~SYNC_ON;

   logic [DW-1:0] div_cnt;
   logic          tick;
   logic [HW-1:0] hcnt;
   logic [VW-1:0] vcnt;

   logic          d_active;
   logic [9:0]    d_x;
   logic [8:0]    d_y;
   logic          d_hsync;
   logic          d_vsync;
   logic          d_frame;

   assign tick = (div_cnt == DIV_LAST);

   // Pixel-clock divider: counts 0..CLK_DIV-1 and wraps on the tick
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // hcnt/vcnt hold the next pixel to emit; vcnt only moves when hcnt wraps
   always_ff @(posedge clk) begin
      if (reset) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (tick) begin
         if (hcnt == H_LAST) begin
            hcnt <= '0;
            if (vcnt == V_LAST) begin
               vcnt <= '0;
            end else begin
               vcnt <= vcnt + 1'b1;
            end
         end else begin
            hcnt <= hcnt + 1'b1;
         end
      end
   end

   // Decode of the pending pixel, registered into the outputs on the next tick
   always_comb begin
      d_active = (hcnt < H_ACT) && (vcnt < V_ACT);
      d_x      = d_active ? 10'(hcnt) : 10'd0;
      d_y      = d_active ? 9'(vcnt) : 9'd0;
      d_hsync  = ((hcnt >= HS_FIRST) && (hcnt <= HS_LAST)) ? SYNC_ON : SYNC_OFF;
      d_vsync  = ((vcnt >= VS_FIRST) && (vcnt <= VS_LAST)) ? SYNC_ON : SYNC_OFF;
      d_frame  = (hcnt == '0) && (vcnt == '0);
   end

   // Output registers: load only on ticks so syncs cannot glitch between pixels
   always_ff @(posedge clk) begin
      if (reset) begin
         vo.active     <= 1'b0;
         vo.xPos       <= '0;
         vo.yPos       <= '0;
         vo.hsync      <= SYNC_OFF;
         vo.vsync      <= SYNC_OFF;
         vo.frameStart <= 1'b0;
      end else if (tick) begin
         vo.active     <= d_active;
         vo.xPos       <= d_x;
         vo.yPos       <= d_y;
         vo.hsync      <= d_hsync;
         vo.vsync      <= d_vsync;
         vo.frameStart <= d_frame;
      end
   end

   // pixTick marks the clk cycle in which freshly loaded pixel outputs are visible
   always_ff @(posedge clk) begin
      if (reset) begin
         vo.pixTick <= 1'b0;
      end else begin
         vo.pixTick <= tick;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen over three parameter sets
module tb_vga_timing_gen;

   typedef struct packed {
      logic       act;
      logic [9:0] x;
      logic [8:0] y;
      logic       hs;
      logic       vs;
      logic       fs;
   } pix_t;

   localparam int NCFG = 3;
   // cfg0: reduced raster; cfg1: CLK_DIV=1 active-high syncs; cfg2: default lines, short frame
   localparam int P_CD  [NCFG] = '{2, 1, 4};
   localparam int P_HA  [NCFG] = '{4, 640, 640};
   localparam int P_HF  [NCFG] = '{1, 16, 16};
   localparam int P_HS  [NCFG] = '{2, 96, 96};
   localparam int P_HB  [NCFG] = '{1, 48, 48};
   localparam int P_VA  [NCFG] = '{3, 3, 2};
   localparam int P_VF  [NCFG] = '{1, 1, 1};
   localparam int P_VS  [NCFG] = '{1, 1, 2};
   localparam int P_VB  [NCFG] = '{1, 1, 1};
   localparam int P_POL [NCFG] = '{0, 1, 0};

   logic   clk = 1'b0;
   logic   reset;
   int     total = 0;
   int     bad = 0;
   longint cyc = 0;
   bit     running = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Expected outputs for the n-th pixel emitted since reset, straight from the raster rules
   function automatic pix_t expect_pix(longint n, int ha, int hf, int hsw, int hb,
                                       int va, int vf, int vsw, int vb, int pol);
      pix_t p;
      int ht = ha + hf + hsw + hb;
      int vt = va + vf + vsw + vb;
      int h = int'(n % ht);
      int v = int'((n / ht) % vt);
      logic on = (pol != 0);
      p.act = (h < ha) && (v < va);
      p.x   = p.act ? 10'(h) : 10'd0;
      p.y   = p.act ? 9'(v) : 9'd0;
      p.hs  = (h >= ha + hf && h < ha + hf + hsw) ? on : ~on;
      p.vs  = (v >= va + vf && v < va + vf + vsw) ? on : ~on;
      p.fs  = (h == 0) && (v == 0);
      return p;
   endfunction

   function automatic pix_t rst_pix(int pol);
      pix_t p;
      p.act = 1'b0;
      p.x   = 10'd0;
      p.y   = 9'd0;
      p.hs  = (pol == 0);
      p.vs  = (pol == 0);
      p.fs  = 1'b0;
      return p;
   endfunction

   function automatic string fmt(pix_t p);
      return $sformatf("act=%b x=%0d y=%0d hs=%b vs=%b fs=%b", p.act, p.x, p.y, p.hs, p.vs, p.fs);
   endfunction

   for (genvar g = 0; g < NCFG; g++) begin : cfg
      localparam int CD  = P_CD[g];
      localparam int HA  = P_HA[g];
      localparam int HF  = P_HF[g];
      localparam int HS  = P_HS[g];
      localparam int HB  = P_HB[g];
      localparam int VA  = P_VA[g];
      localparam int VF  = P_VF[g];
      localparam int VS  = P_VS[g];
      localparam int VB  = P_VB[g];
      localparam int POL = P_POL[g];
      localparam longint FRAME_CLKS = longint'(HA + HF + HS + HB) * (VA + VF + VS + VB) * CD;

      vga_timing_gen_if vif ();

      vga_timing_gen #(
         .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
         .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(POL)
      ) dut (
         .clk   (clk),
         .reset (reset),
         .vo    (vif.master)
      );

      pix_t   q[$];
      pix_t   cur;
      pix_t   got;
      bit     in_rst = 1'b1;
      int     k = 0;
      longint n = 0;
      longint last_fs = 0;
      bit     have_fs = 1'b0;

      // Model: every CLK_DIV-th edge after reset release emits the next pixel in raster order
      always @(posedge clk) begin
         if (reset) begin
            in_rst  = 1'b1;
            k       = 0;
            n       = 0;
            q.delete();
            cur     = rst_pix(POL);
            have_fs = 1'b0;
         end else begin
            in_rst = 1'b0;
            k++;
            if (k % CD == 0) begin
               q.push_back(expect_pix(n, HA, HF, HS, HB, VA, VF, VS, VB, POL));
               n++;
            end
         end
      end

      // Monitor: pops on pixTick, otherwise checks that outputs hold
      always @(negedge clk) begin
         if (running) begin
            got = {vif.active, vif.xPos, vif.yPos, vif.hsync, vif.vsync, vif.frameStart};
            if (in_rst) begin
               total++;
               if (vif.pixTick !== 1'b0 || got !== rst_pix(POL)) begin
                  bad++;
                  $display("FAIL cfg%0d reset_state t=%0d: got tick=%b %s want tick=0 %s",
                           g, cyc, vif.pixTick, fmt(got), fmt(rst_pix(POL)));
               end
            end else if (vif.pixTick === 1'b1) begin
               total++;
               if (q.size() == 0) begin
                  bad++;
                  $display("FAIL cfg%0d unexpected_tick t=%0d: got tick=1 want tick=0", g, cyc);
               end else begin
                  cur = q.pop_front();
                  if (got !== cur) begin
                     bad++;
                     $display("FAIL cfg%0d pixel t=%0d: got %s want %s", g, cyc, fmt(got), fmt(cur));
                  end
                  if (cur.fs) begin
                     if (have_fs) begin
                        total++;
                        if (cyc - last_fs != FRAME_CLKS) begin
                           bad++;
                           $display("FAIL cfg%0d frame_period t=%0d: got %0d clks want %0d clks",
                                    g, cyc, cyc - last_fs, FRAME_CLKS);
                        end
                     end
                     last_fs = cyc;
                     have_fs = 1'b1;
                  end
               end
            end else begin
               total++;
               if (got !== cur || vif.pixTick !== 1'b0) begin
                  bad++;
                  $display("FAIL cfg%0d hold t=%0d: got tick=%b %s want tick=0 %s",
                           g, cyc, vif.pixTick, fmt(got), fmt(cur));
               end
            end
            total++;
            if (q.size() != 0) begin
               bad++;
               $display("FAIL cfg%0d missing_tick t=%0d: got no pixTick want pixTick with %s",
                        g, cyc, fmt(q[0]));
               q.delete();
            end
         end
      end
   end

   // Stimulus: 5-clk power-on reset, random mid-frame resets, then a long free run
   initial begin
      reset = 1'b1;
      @(posedge clk);
      running = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int r = 0; r < 6; r++) begin
         repeat ($urandom_range(200, 6000)) @(negedge clk);
         reset = 1'b1;
         repeat ($urandom_range(1, 4)) @(negedge clk);
         reset = 1'b0;
      end
      repeat (25000) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
